// File: rtl/traffic_fsm_pkg.sv
// Shared direction encoding, phase type and default timing for the intersection controller.
// Lamp vector layout: three bits per direction (N, E, S, W), ordered {red, yellow, green}.
package traffic_fsm_pkg;

  localparam logic [1:0] DIR_N = 2'd0;
  localparam logic [1:0] DIR_E = 2'd1;
  localparam logic [1:0] DIR_S = 2'd2;
  localparam logic [1:0] DIR_W = 2'd3;

  typedef enum logic {
    GREEN  = 1'b0,
    YELLOW = 1'b1
  } phase_e;

  localparam int GREEN_CYCLES_DEF  = 4;
  localparam int YELLOW_CYCLES_DEF = 2;

  function automatic logic [11:0] lamp_decode(input logic [1:0] ps, input phase_e ph);
    logic [11:0] l;
    l = '0;
    for (int d = 0; d < 4; d++) begin
      if (2'(d) == ps) begin
        if (ph == GREEN) l[3*d]   = 1'b1;
        else             l[3*d+1] = 1'b1;
      end else begin
        l[3*d+2] = 1'b1;
      end
    end
    return l;
  endfunction

endpackage

// File: rtl/traffic_rr_arbiter.sv
// Combinational round-robin pick of the first requester after ps_i (ps_i+1, +2, +3).
// Falls back to ps_i with found_o low when nobody else is asking.
module traffic_rr_arbiter (
  input  logic [1:0] ps_i,
  input  logic [3:0] req_i,
  output logic [1:0] winner_o,
  output logic       found_o
);

  logic [1:0] cand;

  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    winner_o = ps_i;
    found_o  = 1'b0;
    cand     = ps_i;
    for (int k = 3; k >= 1; k--) begin
      cand = ps_i + 2'(k);
      if (req_i[cand]) begin
        winner_o = cand;
        found_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/traffic_fsm.sv
// Four-way light controller: round-robin right-of-way with min green dwell and fixed yellow.
// Lamps are registered (Moore); NS is combinational from registered state and requests.
module traffic_fsm
  import traffic_fsm_pkg::*;
#(
  parameter int GREEN_CYCLES  = GREEN_CYCLES_DEF,
  parameter int YELLOW_CYCLES = YELLOW_CYCLES_DEF
) (
  input  logic       A,
  input  logic       B,
  input  logic       C,
  input  logic       D,
  input  logic       clk,
  input  logic       reset,
  output logic       red_north,
  output logic       yellow_north,
  output logic       green_north,
  output logic       red_east,
  output logic       yellow_east,
  output logic       green_east,
  output logic       red_south,
  output logic       yellow_south,
  output logic       green_south,
  output logic       red_west,
  output logic       yellow_west,
  output logic       green_west,
  output logic [1:0] PS,
  output logic [1:0] NS
);

  localparam int MAXC  = (GREEN_CYCLES > YELLOW_CYCLES) ? GREEN_CYCLES : YELLOW_CYCLES;
  localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CNT_W-1:0] G_LAST = CNT_W'(GREEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(YELLOW_CYCLES - 1);

  logic [1:0]       ps_q, ps_d;
  phase_e           phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       tgt_q, tgt_d;
  logic [11:0]      lamp_q;

  logic [1:0] winner;
  logic       found;

  traffic_rr_arbiter u_arb (
    .ps_i     (ps_q),
    .req_i    ({D, C, B, A}),
    .winner_o (winner),
    .found_o  (found)
  );

  always_comb begin
    ps_d    = ps_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    case (phase_q)
      GREEN: begin
        if (cnt_q == G_LAST) begin
          // Counter sits saturated here; green holds until someone else asks.
          if (found) begin
            phase_d = YELLOW;
            tgt_d   = winner;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        if (cnt_q == Y_LAST) begin
          ps_d    = tgt_q;
          phase_d = GREEN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  // Lamps are loaded from next-state so they track ps_q/phase_q with no extra cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      ps_q    <= DIR_N;
      phase_q <= GREEN;
      cnt_q   <= '0;
      tgt_q   <= DIR_N;
      lamp_q  <= lamp_decode(DIR_N, GREEN);
    end else begin
      ps_q    <= ps_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      lamp_q  <= lamp_decode(ps_d, phase_d);
    end
  end

  assign PS = ps_q;
  assign NS = (phase_q == GREEN) ? winner : tgt_q;

  assign green_north  = lamp_q[0];
  assign yellow_north = lamp_q[1];
  assign red_north    = lamp_q[2];
  assign green_east   = lamp_q[3];
  assign yellow_east  = lamp_q[4];
  assign red_east     = lamp_q[5];
  assign green_south  = lamp_q[6];
  assign yellow_south = lamp_q[7];
  assign red_south    = lamp_q[8];
  assign green_west   = lamp_q[9];
  assign yellow_west  = lamp_q[10];
  assign red_west     = lamp_q[11];

endmodule

// File: tb/tb_traffic_fsm.sv
// Directed bench for traffic_fsm: stimulus pushes per-cycle expectations, a negedge monitor checks them.
module tb_traffic_fsm;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic A = 1'b0, B = 1'b0, C = 1'b0, D = 1'b0;
  logic red_north, yellow_north, green_north;
  logic red_east, yellow_east, green_east;
  logic red_south, yellow_south, green_south;
  logic red_west, yellow_west, green_west;
  logic [1:0] PS, NS;

  always #5 clk = ~clk;

  traffic_fsm dut (
    .A(A), .B(B), .C(C), .D(D),
    .clk(clk), .reset(reset),
    .red_north(red_north), .yellow_north(yellow_north), .green_north(green_north),
    .red_east(red_east), .yellow_east(yellow_east), .green_east(green_east),
    .red_south(red_south), .yellow_south(yellow_south), .green_south(green_south),
    .red_west(red_west), .yellow_west(yellow_west), .green_west(green_west),
    .PS(PS), .NS(NS)
  );

  typedef struct packed {
    logic [1:0] ps;
    logic       y;
    logic [1:0] ns;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int checks = 0;
  int failures = 0;

  task automatic chk_eq(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, got, want);
    end
  endtask

  // Drive one cycle of inputs right after the edge; expectation describes this interval.
  task automatic cyc(input bit rst, input logic [3:0] req, input bit chk,
                     input logic [1:0] ps, input bit y, input logic [1:0] ns, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst;
    {D, C, B, A} = req;
    if (chk) begin
      e.ps = ps;
      e.y  = y;
      e.ns = ns;
      exp_q.push_back(e);
      name_q.push_back(nm);
    end
  endtask

  initial begin : monitor
    exp_t        e;
    string       nm;
    logic [11:0] got, want;
    int          nonred;
    bit          onehot;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        got = {red_west, yellow_west, green_west, red_south, yellow_south, green_south,
               red_east, yellow_east, green_east, red_north, yellow_north, green_north};
        want = '0;
        nonred = 0;
        onehot = 1'b1;
        for (int d = 0; d < 4; d++) begin
          if (2'(d) == e.ps) want[3*d +: 3] = e.y ? 3'b010 : 3'b001;
          else               want[3*d +: 3] = 3'b100;
          if ($countones(got[3*d +: 3]) != 1) onehot = 1'b0;
          if (got[3*d+2] == 1'b0) nonred++;
        end
        chk_eq({nm, "_PS"}, int'(PS), int'(e.ps));
        chk_eq({nm, "_NS"}, int'(NS), int'(e.ns));
        chk_eq({nm, "_lamps"}, int'(got), int'(want));
        chk_eq({nm, "_one_lamp_per_dir"}, int'(onehot), 1);
        chk_eq({nm, "_one_nonred_dir"}, nonred, 1);
      end
    end
  end

  initial begin : stimulus
    // Reset across two edges, then idle
    cyc(1, 4'b0000, 0, 0, 0, 0, "pre");
    cyc(1, 4'b0000, 1, 0, 0, 0, "reset");
    repeat (20) cyc(0, 4'b0000, 1, 0, 0, 0, "idle_hold");
    repeat (10) cyc(0, 4'b0001, 1, 0, 0, 0, "own_req");

    // South request alone
    cyc(1, 4'b0000, 1, 0, 0, 0, "reset2");
    repeat (4) cyc(0, 4'b0100, 1, 0, 0, 2, "c_green");
    repeat (2) cyc(0, 4'b0100, 1, 0, 1, 2, "c_yellow");
    cyc(0, 4'b0100, 1, 2, 0, 2, "c_south");
    cyc(0, 4'b0000, 1, 2, 0, 2, "south_hold");

    // Request dropped during yellow still lands on South
    cyc(1, 4'b0000, 1, 2, 0, 2, "reset3");
    repeat (4) cyc(0, 4'b0100, 1, 0, 0, 2, "drop_green");
    repeat (2) cyc(0, 4'b0000, 1, 0, 1, 2, "drop_yellow");
    cyc(0, 4'b0000, 1, 2, 0, 2, "drop_land");

    // Reset in the middle of yellow_north
    cyc(1, 4'b0000, 1, 2, 0, 2, "reset4");
    repeat (4) cyc(0, 4'b0100, 1, 0, 0, 2, "ry_green");
    cyc(1, 4'b0100, 1, 0, 1, 2, "ry_rst_in_yellow");
    repeat (4) cyc(0, 4'b0100, 1, 0, 0, 2, "ry_restart_green");
    repeat (2) cyc(0, 4'b0100, 1, 0, 1, 2, "ry_yellow");
    cyc(0, 4'b0100, 1, 2, 0, 2, "ry_south");

    // East and South together: East first, then South
    cyc(1, 4'b0000, 1, 2, 0, 2, "reset5");
    repeat (4) cyc(0, 4'b0110, 1, 0, 0, 1, "bc_n_green");
    repeat (2) cyc(0, 4'b0110, 1, 0, 1, 1, "bc_n_yellow");
    repeat (4) cyc(0, 4'b0110, 1, 1, 0, 2, "bc_e_green");
    repeat (2) cyc(0, 4'b0110, 1, 1, 1, 2, "bc_e_yellow");
    cyc(0, 4'b0110, 1, 2, 0, 1, "bc_s_green");

    // All four requesting: strict rotation with a 6-cycle period
    cyc(1, 4'b0000, 1, 2, 0, 2, "reset6");
    for (int d = 0; d < 4; d++) begin
      repeat (4) cyc(0, 4'b1111, 1, 2'(d), 0, 2'((d + 1) % 4), "all_green");
      repeat (2) cyc(0, 4'b1111, 1, 2'(d), 1, 2'((d + 1) % 4), "all_yellow");
    end
    cyc(0, 4'b1111, 1, 0, 0, 1, "all_wrap");

    @(negedge clk);
    #1;
    chk_eq("queue_drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
